i2c_bus_arbiter: RTL and testbench
==================================

Name: i2c_bus_arbiter

Overview:
- Shares one I2C master command port between NUM_REQ on-board requesters, e.g. switch poller (read 0x57), LED writer, FND writer.
- Each requester posts a single-byte transaction (7-bit addr, R/W, wdata).
- Arbiter grants round-robin, launches the master, and returns rdata/NACK status to the winning requester.
- Sits between requester logic and the I2C master in the top level.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- WDOG_CYCLES, 2000000, watchdog limit in clk cycles (20 ms @ 100 MHz); used only with I2C_ARB_WDOG_EN

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_REQ  per-requester request level
- req_addr  in  NUM_REQ*7  flattened 7-bit slave addresses; requester i at [7i+6:7i]
- req_rw  in  NUM_REQ  1=read, 0=write
- req_wdata  in  NUM_REQ*8  flattened write bytes
- gnt  out  NUM_REQ  one-hot; high from grant until the done cycle inclusive
- done  out  NUM_REQ  one-hot, one-cycle completion pulse
- rdata  out  8  read byte; valid in the done cycle, held until the next done
- nack  out  1  address/data NACK or watchdog abort; valid with done
- m_start  out  1  one-cycle launch pulse to master
- m_addr  out  7  latched address
- m_rw  out  1  latched R/W
- m_wdata  out  8  latched write byte
- m_busy  in  1  master busy
- m_done  in  1  master one-cycle completion pulse
- m_rdata  in  8  master read byte
- m_nack  in  1  master NACK flag, valid with m_done
- m_abort  out  1  one-cycle abort pulse to master (held 0 without I2C_ARB_WDOG_EN)

Behaviour:
- Reset: state IDLE; gnt=0, done=0, rdata=0, nack=0, m_start=0, m_addr=0, m_rw=0, m_wdata=0, m_abort=0; rr pointer=0.
- A reset mid-transaction drops gnt immediately with no done pulse. The master is reset by the same rst.
- IDLE, entered when req != 0 and m_busy=0:
  - Winner is the first set bit searching from ptr, ptr+1, … mod NUM_REQ.
  - Latch the winner's addr/rw/wdata into m_* and set gnt[w].
  - Go to ISSUE next cycle.
  - If m_busy=1, stay in IDLE.
- ISSUE: m_start=1 for exactly one cycle. Go to WAIT_DONE.
- WAIT_DONE:
  - On m_done: capture rdata<=m_rdata only when m_rw=1 (otherwise hold), nack<=m_nack. Go to RESP.
  - m_done in the same cycle as ISSUE cannot occur (master contract); it is ignored if it does.
- RESP:
  - done[w]=1 for one cycle, with gnt[w] still high.
  - ptr<=(w+1) mod NUM_REQ; clear gnt next cycle. Go to IDLE.
- Grant latency: req rising in IDLE → gnt next cycle → m_start the cycle after.
- Requester contract:
  - Hold req and fields stable until done.
  - Drop req in the done cycle or the cycle after; a req still high in IDLE is a new request.
  - Field changes after grant have no effect, because fields are latched.
- req deasserted during WAIT_DONE: the transaction completes and done still pulses.
- Simultaneous requests: strict rotation. With ptr=0 and req=3'b111, the grant order is 0,1,2,0.
- ptr wraps NUM_REQ-1 → 0.
- m_* fields hold their last values while idle.

Optional Feature:
- Macro: I2C_ARB_WDOG_EN.
- Defined:
  - A counter clears on ISSUE and increments in WAIT_DONE.
  - On reaching WDOG_CYCLES-1 without m_done: pulse m_abort one cycle, set nack=1, leave rdata unchanged, go to RESP (normal done pulse and rotation).
  - If m_done arrives in the same cycle as the limit, m_done wins and there is no abort.
- Undefined: no counter; m_abort tied 0; WAIT_DONE waits indefinitely.

Decomposition:
- Package i2c_arb_pkg: state_t enum (IDLE, ISSUE, WAIT_DONE, RESP) and constants SW_SLAVE_ADDR=7'h57, I2C_RD=1'b1, I2C_WR=1'b0.
- One sub-module: rr_picker. Combinational round-robin priority encoder with inputs req and ptr, outputs one-hot grant and index.

Test Plan:
1. Single read: req[0] with addr 0x57, rw=1; master returns m_rdata=0xA5, m_nack=0 → m_start two cycles after req, m_addr=0x57; done[0] one cycle after m_done; rdata=0xA5, nack=0.
2. Write NACK: req[1] with addr 0x20, rw=0, wdata=0x3C; m_nack=1 → m_wdata=0x3C; done[1] with nack=1; rdata keeps the prior value 0xA5.
3. Contention: req=3'b111 held, ptr=0 → grants in order 0,1,2,0; each gnt is one-hot; never two m_start pulses without an intervening m_done.
4. Busy gate: m_busy=1 with req[2] set → no gnt while busy; gnt[2] one cycle after m_busy falls.
5. Reset mid-op: rst asserted in WAIT_DONE → next cycle all outputs are at reset values, no done pulse, and the next arbitration starts from ptr=0.
6. Watchdog (I2C_ARB_WDOG_EN, WDOG_CYCLES=100): no m_done → m_abort pulse 100 cycles after m_start, then done with nack=1; a second case with m_done landing on cycle 99 → no abort.

Source files
------------

// File: rtl/i2c_bus_arbiter_pkg.sv
// i2c_arb_pkg: FSM states and I2C constants shared by the i2c_bus_arbiter files.
package i2c_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;
  localparam logic [6:0] SW_SLAVE_ADDR = 7'h57;
  localparam logic I2C_RD = 1'b1;
  localparam logic I2C_WR = 1'b0;
endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// i2c_bus_arbiter_if: requester-side and I2C-master-side signals of the arbiter.
interface i2c_bus_arbiter_if #(parameter int NUM_REQ = 3);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*7-1:0] req_addr;
  logic [NUM_REQ-1:0] req_rw;
  logic [NUM_REQ*8-1:0] req_wdata;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] done;
  logic [7:0] rdata;
  logic nack;
  logic m_start;
  logic [6:0] m_addr;
  logic m_rw;
  logic [7:0] m_wdata;
  logic m_busy;
  logic m_done;
  logic [7:0] m_rdata;
  logic m_nack;
  logic m_abort;
  modport master (
    input req, req_addr, req_rw, req_wdata, m_busy, m_done, m_rdata, m_nack,
    output gnt, done, rdata, nack, m_start, m_addr, m_rw, m_wdata, m_abort
  );
  modport slave (
    output req, req_addr, req_rw, req_wdata, m_busy, m_done, m_rdata, m_nack,
    input gnt, done, rdata, nack, m_start, m_addr, m_rw, m_wdata, m_abort
  );
endinterface

// File: rtl/i2c_bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder, first set req at or after ptr.
module rr_picker
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);
  logic [IW-1:0] j;
  // Scan from farthest to nearest so the closest candidate to ptr is the last to win.
  always_comb begin
    idx = '0;
    j = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % NUM_REQ);
      idx = req[j] ? j : idx;
    end
    grant = '0;
    grant[idx] = |req;
  end
endmodule

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin sharing of one I2C master command port between NUM_REQ requesters.
// Define I2C_ARB_WDOG_EN to abort a transfer the master has not finished within WDOG_CYCLES.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int WDOG_CYCLES = 2000000
) (
  input logic clk,
  input logic rst,
  i2c_bus_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] w;
  logic [IW-1:0] pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [6:0] sel_addr;
  logic sel_rw;
  logic [7:0] sel_wdata;
  logic wd_hit;
  logic md;
  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req(bus.req),
    .ptr(ptr),
    .grant(pick_gnt),
    .idx(pick_idx)
  );
  always_comb begin
    sel_addr = '0;
    sel_rw = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr = pick_gnt[i] ? bus.req_addr[i*7 +: 7] : sel_addr;
      sel_rw = pick_gnt[i] ? bus.req_rw[i] : sel_rw;
      sel_wdata = pick_gnt[i] ? bus.req_wdata[i*8 +: 8] : sel_wdata;
    end
  end
  // A completion coinciding with the launch pulse breaks the master contract and is dropped.
  assign md = bus.m_done & ~bus.m_start;
`ifdef I2C_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wd;
  assign wd_hit = wd == WW'(WDOG_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst || state == ISSUE) wd <= '0;
    else if (state == WAIT_DONE && !wd_hit) wd <= wd + 1'b1;
  end
`else
  assign wd_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      w <= '0;
      bus.gnt <= '0;
      bus.done <= '0;
      bus.rdata <= '0;
      bus.nack <= 1'b0;
      bus.m_start <= 1'b0;
      bus.m_addr <= '0;
      bus.m_rw <= 1'b0;
      bus.m_wdata <= '0;
      bus.m_abort <= 1'b0;
    end else begin
      bus.m_start <= 1'b0;
      bus.m_abort <= 1'b0;
      bus.done <= '0;
      case (state)
        IDLE: if (|bus.req && !bus.m_busy) begin
          state <= ISSUE;
          w <= pick_idx;
          bus.gnt <= pick_gnt;
          bus.m_addr <= sel_addr;
          bus.m_rw <= sel_rw;
          bus.m_wdata <= sel_wdata;
        end
        ISSUE: begin
          state <= WAIT_DONE;
          bus.m_start <= 1'b1;
        end
        WAIT_DONE: if (md || wd_hit) begin
          state <= RESP;
          bus.done <= bus.gnt;
          bus.nack <= md ? bus.m_nack : 1'b1;
          bus.m_abort <= ~md;
          bus.rdata <= (md && bus.m_rw) ? bus.m_rdata : bus.rdata;
        end
        RESP: begin
          state <= IDLE;
          bus.gnt <= '0;
          ptr <= (w == IW'(NUM_REQ - 1)) ? '0 : w + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: scoreboard bench for i2c_bus_arbiter with a small I2C master responder.
module tb_i2c_bus_arbiter;
  import i2c_arb_pkg::*;
  localparam int N = 3;
  typedef struct {logic [N-1:0] gnt; logic [6:0] addr; logic rw; logic [7:0] wdata;} start_t;
  typedef struct {logic [N-1:0] done; logic [7:0] rdata; logic nack; logic abort;} done_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  i2c_bus_arbiter_if #(.NUM_REQ(N)) bus ();
  i2c_bus_arbiter #(.NUM_REQ(N), .WDOG_CYCLES(100)) dut (.clk(clk), .rst(rst), .bus(bus));

  start_t sq[$];
  done_t dq[$];
  start_t s;
  done_t d;
  int tests = 0;
  int fails = 0;
  int n_done = 0;
  int n_start = 0;
  int cyc = 0;
  int t_start = 0;
  int t_abort = 0;
  bit inflight = 0;
  bit prev_mdone = 0;
  logic [7:0] exp_rdata = 8'h00;
  bit resp_en = 1;
  int resp_delay = 2;
  logic [7:0] resp_rdata = 8'h00;
  logic resp_nack = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [6:0] a, logic rw, logic [7:0] wd);
    bus.req[i] = 1'b1;
    bus.req_addr[i*7 +: 7] = a;
    bus.req_rw[i] = rw;
    bus.req_wdata[i*8 +: 8] = wd;
  endtask

  task automatic expect_txn(int i, logic [6:0] a, logic rw, logic [7:0] wd, logic [7:0] rd, logic nk, logic ab);
    sq.push_back('{N'(1) << i, a, rw, wd});
    if (rw && !ab) exp_rdata = rd;
    dq.push_back('{N'(1) << i, exp_rdata, ab ? 1'b1 : nk, ab});
  endtask

  task automatic wait_dones(int target, string name);
    int c = 0;
    while (n_done < target && c < 400) begin
      tick();
      c++;
    end
    chk(name, n_done, target);
  endtask

  task automatic wait_starts(int target, string name);
    int c = 0;
    while (n_start < target && c < 400) begin
      tick();
      c++;
    end
    chk(name, n_start, target);
  endtask

  // Scoreboard monitor: every launch and every completion must match the next queued expectation.
  always @(negedge clk) begin
    cyc++;
    if (rst) inflight = 0;
    else begin
      if (bus.m_start) begin
        n_start++;
        t_start = cyc;
        chk("start_overlap", inflight, 0);
        inflight = 1;
        if (sq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL start_unexpected: got m_start addr=%h with empty queue, required none", bus.m_addr);
        end else begin
          s = sq.pop_front();
          chk("start_gnt", bus.gnt, s.gnt);
          chk("start_addr", bus.m_addr, s.addr);
          chk("start_rw", bus.m_rw, s.rw);
          if (!s.rw) chk("start_wdata", bus.m_wdata, s.wdata);
        end
      end
      if (|bus.done || bus.m_abort) begin
        n_done++;
        if (bus.m_abort) t_abort = cyc;
        if (!bus.m_abort) chk("done_latency", prev_mdone, 1);
        if (dq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done_unexpected: got done=%b abort=%b with empty queue, required none", bus.done, bus.m_abort);
        end else begin
          d = dq.pop_front();
          chk("done_onehot", bus.done, d.done);
          chk("done_gnt", bus.gnt, d.done);
          chk("done_rdata", bus.rdata, d.rdata);
          chk("done_nack", bus.nack, d.nack);
          chk("done_abort", bus.m_abort, d.abort);
        end
      end
      if (bus.m_done || bus.m_abort) inflight = 0;
    end
    prev_mdone = bus.m_done;
  end

  // Master model: answers each m_start with m_done resp_delay cycles later.
  initial begin
    bus.m_done = 1'b0;
    bus.m_rdata = 8'h00;
    bus.m_nack = 1'b0;
    forever begin
      tick();
      bus.m_done = 1'b0;
      if (bus.m_start && resp_en) begin
        repeat (resp_delay) tick();
        bus.m_done = 1'b1;
        bus.m_rdata = resp_rdata;
        bus.m_nack = resp_nack;
      end
    end
  end

  initial begin
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_rw = '0;
    bus.req_wdata = '0;
    bus.m_busy = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_state", {bus.gnt, bus.done, bus.rdata, bus.nack, bus.m_start, bus.m_addr, bus.m_rw, bus.m_wdata, bus.m_abort}, 0);
    tick();
    rst = 1'b0;
    tick();

    // single read from the switch poller
    resp_en = 1; resp_delay = 3; resp_rdata = 8'hA5; resp_nack = 1'b0;
    expect_txn(0, SW_SLAVE_ADDR, I2C_RD, 8'h00, 8'hA5, 1'b0, 1'b0);
    set_req(0, SW_SLAVE_ADDR, I2C_RD, 8'h00);
    @(negedge clk);
    chk("lat_req_cycle", {bus.gnt, bus.m_start}, {3'b000, 1'b0});
    @(negedge clk);
    chk("lat_gnt", {bus.gnt, bus.m_start}, {3'b001, 1'b0});
    @(negedge clk);
    chk("lat_start", {bus.gnt, bus.m_start}, {3'b001, 1'b1});
    wait_dones(1, "t1_done");
    bus.req[0] = 1'b0;

    // write answered with NACK; rdata must keep 0xA5
    resp_rdata = 8'hEE; resp_nack = 1'b1;
    expect_txn(1, 7'h20, I2C_WR, 8'h3C, 8'hEE, 1'b1, 1'b0);
    set_req(1, 7'h20, I2C_WR, 8'h3C);
    wait_dones(2, "t2_done");
    bus.req[1] = 1'b0;

    // busy gate
    resp_rdata = 8'h42; resp_nack = 1'b0;
    bus.m_busy = 1'b1;
    expect_txn(2, 7'h30, I2C_RD, 8'h00, 8'h42, 1'b0, 1'b0);
    set_req(2, 7'h30, I2C_RD, 8'h00);
    repeat (3) begin
      @(negedge clk);
      chk("busy_no_gnt", bus.gnt, 3'b000);
    end
    tick();
    bus.m_busy = 1'b0;
    @(negedge clk);
    chk("busy_fall_cycle", bus.gnt, 3'b000);
    @(negedge clk);
    chk("busy_gnt_after", bus.gnt, 3'b100);
    wait_dones(3, "t4_done");
    bus.req[2] = 1'b0;

    // contention from ptr=0: grants 0,1,2,0
    resp_delay = 2; resp_rdata = 8'h11;
    expect_txn(0, SW_SLAVE_ADDR, I2C_RD, 8'h00, 8'h11, 1'b0, 1'b0);
    expect_txn(1, 7'h20, I2C_WR, 8'h3C, 8'h11, 1'b0, 1'b0);
    expect_txn(2, 7'h31, I2C_WR, 8'h77, 8'h11, 1'b0, 1'b0);
    expect_txn(0, SW_SLAVE_ADDR, I2C_RD, 8'h00, 8'h11, 1'b0, 1'b0);
    set_req(0, SW_SLAVE_ADDR, I2C_RD, 8'h00);
    set_req(1, 7'h20, I2C_WR, 8'h3C);
    set_req(2, 7'h31, I2C_WR, 8'h77);
    wait_dones(7, "t3_done");
    bus.req = '0;

    // reset in WAIT_DONE: no done, outputs cleared, ptr back to 0
    resp_en = 0;
    sq.push_back('{3'b010, 7'h21, I2C_RD, 8'h00});
    set_req(1, 7'h21, I2C_RD, 8'h00);
    wait_starts(8, "t5_start");
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = '0;
    @(negedge clk);
    chk("midop_reset", {bus.gnt, bus.done, bus.rdata, bus.nack, bus.m_start, bus.m_addr, bus.m_rw, bus.m_wdata, bus.m_abort}, 0);
    tick();
    exp_rdata = 8'h00;
    resp_en = 1; resp_rdata = 8'h33;
    expect_txn(0, SW_SLAVE_ADDR, I2C_RD, 8'h00, 8'h33, 1'b0, 1'b0);
    expect_txn(1, 7'h20, I2C_WR, 8'h5C, 8'h33, 1'b0, 1'b0);
    set_req(0, SW_SLAVE_ADDR, I2C_RD, 8'h00);
    set_req(1, 7'h20, I2C_WR, 8'h5C);
    wait_dones(9, "t5_after");
    bus.req = '0;

`ifdef I2C_ARB_WDOG_EN
    // silent master: abort 100 cycles after m_start
    resp_en = 0;
    expect_txn(2, 7'h30, I2C_RD, 8'h00, 8'h00, 1'b1, 1'b1);
    set_req(2, 7'h30, I2C_RD, 8'h00);
    wait_dones(10, "wdog_abort_done");
    chk("wdog_latency", t_abort - t_start, 100);
    bus.req[2] = 1'b0;
    tick();
    // m_done on cycle 99 beats the watchdog
    resp_en = 1; resp_delay = 99; resp_rdata = 8'h5A; resp_nack = 1'b0;
    expect_txn(2, 7'h30, I2C_RD, 8'h00, 8'h5A, 1'b0, 1'b0);
    set_req(2, 7'h30, I2C_RD, 8'h00);
    wait_dones(11, "wdog_edge_done");
    bus.req[2] = 1'b0;
`endif

    repeat (4) tick();
    chk("start_queue_empty", sq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, required earlier finish");
    $fatal(1, "timeout");
  end
endmodule
